scroll_ctrl: RTL and testbench

Upstream control stage for the 8-digit HEX marquee. It turns raw DE2 pushbuttons into debounced user commands: pause/run, reverse direction, faster and slower. It divides CLOCK_50 to the selected scroll rate and outputs the current frame index, plus a one-cycle step strobe. The marquee glyph stage consumes `frame` and `step` and renders one display pattern per index.

---
 rtl/scroll_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_scroll_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_ctrl.sv
// ---------------------------------------------------------------------------
// scroll_ctrl
//
// Upstream control stage for the 8-digit HEX marquee. It turns the four raw
// DE2 pushbuttons into debounced user commands, divides CLOCK_50 down to the
// selected scroll rate and keeps the current frame index for the glyph stage.
//
// Parameters
//    CLK_HZ       input clock frequency in Hz
//    DEBOUNCE_MS  time a key level must be stable before it is accepted
//    NUM_FRAMES   number of frame indices (2..16), frame wraps in 0..NUM_FRAMES-1
//
// Ports
//    CLOCK_50  in   system clock, all state on the rising edge
//    RESET     in   asynchronous active-high reset
//    KEY[3:0]  in   raw pushbuttons, active-low, asynchronous to CLOCK_50
//                   KEY[0] pause toggle, KEY[1] direction toggle,
//                   KEY[2] faster, KEY[3] slower
//    frame     out  current frame index
//    step      out  one-cycle pulse in the cycle frame takes a new value
//    paused    out  1 = scrolling halted
//    dir       out  0 = forward (increment), 1 = reverse (decrement)
//    speed     out  rate level, 0..3 = 1000/500/250/125 ms per frame
// ---------------------------------------------------------------------------
module scroll_ctrl #(
   parameter int CLK_HZ      = 50000000,
   parameter int DEBOUNCE_MS = 10,
   parameter int NUM_FRAMES  = 15
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic [3:0] KEY,
   output logic [3:0] frame,
   output logic       step,
   output logic       paused,
   output logic       dir,
   output logic [1:0] speed
);

   // ------------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------------
   localparam int TICKS_PER_MS = CLK_HZ / 1000;

   // Debounce window in clock cycles; the counter only ever needs 0..DB-1.
   localparam int DB   = TICKS_PER_MS * DEBOUNCE_MS;
   localparam int DB_W = (DB > 1) ? $clog2(DB) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB - 1);

   // The slowest rate sets the prescaler width; it counts 0..PERIOD-1.
   localparam int PERIOD_MAX = TICKS_PER_MS * 1000;
   localparam int PRE_W      = (PERIOD_MAX > 1) ? $clog2(PERIOD_MAX) : 1;

   localparam logic [PRE_W-1:0] LAST_SPEED0 = PRE_W'(TICKS_PER_MS * 1000 - 1);
   localparam logic [PRE_W-1:0] LAST_SPEED1 = PRE_W'(TICKS_PER_MS * 500 - 1);
   localparam logic [PRE_W-1:0] LAST_SPEED2 = PRE_W'(TICKS_PER_MS * 250 - 1);
   localparam logic [PRE_W-1:0] LAST_SPEED3 = PRE_W'(TICKS_PER_MS * 125 - 1);

   localparam logic [3:0] FRAME_LAST = 4'(NUM_FRAMES - 1);

   // ------------------------------------------------------------------------
   // Internal signals
   // ------------------------------------------------------------------------
   logic [3:0]       key_meta;
   logic [3:0]       key_sync;
   logic [3:0]       key_stable;
   logic [DB_W-1:0]  db_cnt [4];
   logic [3:0]       press;

   logic             pause_ev;
   logic             dir_ev;
   logic             faster_ev;
   logic             slower_ev;

   logic [1:0]       speed_next;
   logic             speed_change;

   logic [PRE_W-1:0] pre_cnt;
   logic [PRE_W-1:0] period_last;
   logic             tick;
   logic [3:0]       frame_next;

   // ------------------------------------------------------------------------
   // Two-flop synchronizer per key. The buttons are released (high) out of
   // reset so that a key held through reset is seen as a fresh press once
   // it has been debounced, never as a spurious release.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         key_meta <= 4'hF;
         key_sync <= 4'hF;
      end else begin
         key_meta <= KEY;
         key_sync <= key_meta;
      end
   end

   // ------------------------------------------------------------------------
   // Debounce. Each key counts how long the synchronized level has disagreed
   // with its accepted (stable) level. Any cycle of agreement clears the
   // count, so bounce shorter than the window never gets accepted. Once the
   // disagreement has lasted the full window the stable level flips.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         key_stable <= 4'hF;
         for (int i = 0; i < 4; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (key_sync[i] == key_stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               key_stable[i] <= key_sync[i];
               db_cnt[i]     <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Press detection. A press is the single cycle in which a released key's
   // stable level is about to flip to pressed, so the command registers
   // update on the very edge the stable level changes. Releases and a key
   // that stays held produce nothing further.
   // ------------------------------------------------------------------------
   always_comb begin
      press = '0;
      for (int i = 0; i < 4; i++) begin
         press[i] = key_stable[i] & ~key_sync[i] & (db_cnt[i] == DB_LAST);
      end
   end

   assign pause_ev  = press[0];
   assign dir_ev    = press[1];
   assign faster_ev = press[2];
   assign slower_ev = press[3];

   // ------------------------------------------------------------------------
   // Speed selection. Faster and slower saturate at the ends of the range
   // and cancel each other when both arrive together. speed_change is only
   // raised when the level really moves, since that is what restarts the
   // prescaler.
   // ------------------------------------------------------------------------
   always_comb begin
      speed_next = speed;
      if (faster_ev && !slower_ev && (speed != 2'd3)) begin
         speed_next = speed + 2'd1;
      end else if (slower_ev && !faster_ev && (speed != 2'd0)) begin
         speed_next = speed - 2'd1;
      end
      speed_change = (speed_next != speed);
   end

   // ------------------------------------------------------------------------
   // Terminal count for the current rate and the tick it produces. Both are
   // based on the pre-edge speed and paused values, so a command arriving in
   // the same cycle as a tick never suppresses or reshapes that tick.
   // ------------------------------------------------------------------------
   always_comb begin
      period_last = LAST_SPEED2;
      case (speed)
         2'd0:    period_last = LAST_SPEED0;
         2'd1:    period_last = LAST_SPEED1;
         2'd2:    period_last = LAST_SPEED2;
         default: period_last = LAST_SPEED3;
      endcase
      tick = !paused && (pre_cnt >= period_last);
   end

   // ------------------------------------------------------------------------
   // Next frame index, wrapping at both ends of 0..NUM_FRAMES-1 in the
   // direction that was in force before this edge.
   // ------------------------------------------------------------------------
   always_comb begin
      frame_next = frame;
      if (tick) begin
         if (dir) begin
            frame_next = (frame == 4'd0) ? FRAME_LAST : frame - 4'd1;
         end else begin
            frame_next = (frame == FRAME_LAST) ? 4'd0 : frame + 4'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Prescaler. A real speed change always restarts the count, even while
   // paused or on a tick. Pausing freezes the count so that resuming picks
   // up exactly where the period left off.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         pre_cnt <= '0;
      end else if (speed_change) begin
         pre_cnt <= '0;
      end else if (paused) begin
         pre_cnt <= pre_cnt;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Registered outputs. Every user-visible signal comes from a flop, so
   // there is no combinational path from KEY to the glyph stage.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         frame  <= 4'd0;
         step   <= 1'b0;
         paused <= 1'b0;
         dir    <= 1'b0;
         speed  <= 2'd2;
      end else begin
         frame  <= frame_next;
         step   <= tick;
         paused <= paused ^ pause_ev;
         dir    <= dir ^ dir_ev;
         speed  <= speed_next;
      end
   end

endmodule

// File: tb/tb_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scroll_ctrl
//
// Bench for scroll_ctrl with CLK_HZ = 1000 and DEBOUNCE_MS = 2, so one
// millisecond is one cycle and the debounce window is 2 cycles. The stimulus
// process queues the hand-computed cycle and frame of every expected step; a
// separate monitor pops an entry each time the DUT raises step.
// ---------------------------------------------------------------------------
module tb_scroll_ctrl;

   localparam int CLK_HZ      = 1000;
   localparam int DEBOUNCE_MS = 2;
   localparam int NUM_FRAMES  = 15;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] key;
   logic [3:0] frame;
   logic       step;
   logic       paused;
   logic       dir;
   logic [1:0] speed;

   int cyc    = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      int cyc;
      int frame;
   } step_t;

   step_t exp_q[$];
   step_t mon_e;

   scroll_ctrl #(
      .CLK_HZ      (CLK_HZ),
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .NUM_FRAMES  (NUM_FRAMES)
   ) dut (
      .CLOCK_50 (clock),
      .RESET    (reset),
      .KEY      (key),
      .frame    (frame),
      .step     (step),
      .paused   (paused),
      .dir      (dir),
      .speed    (speed)
   );

   // Free-running clock and a cycle counter that names each rising edge.
   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc <= cyc + 1;
   end

   // One comparison with its FAIL report.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                  name, actual, expected, cyc);
      end
   endtask

   // Press (drive low) or release (drive high) the keys selected by mask.
   task automatic applyStimulus(input logic [3:0] mask, input logic pressed);
      if (pressed) begin
         key = key & ~mask;
      end else begin
         key = key | mask;
      end
   endtask

   task automatic pushStep(input int at, input int fr);
      step_t e;
      e.cyc   = at;
      e.frame = fr;
      exp_q.push_back(e);
   endtask

   // Advance to the falling edge that follows rising edge number t.
   task automatic waitUntil(input int t);
      while (cyc < t) begin
         @(negedge clock);
      end
   endtask

   // Monitor: every step pulse must match the next queued expectation.
   always @(negedge clock) begin
      if (step === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_step: step high at cycle %0d with frame %0d, expected no step",
                     cyc, frame);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("step_cycle", cyc, mon_e.cyc);
            checkOutput("step_frame", {28'd0, frame}, mon_e.frame);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   int s;
   int r0;
   int r1;
   int t;
   int slower_exp [4] = '{2, 1, 0, 0};

   initial begin
      reset = 1'b1;
      key   = 4'hF;

      // Reset state.
      @(negedge clock);
      checkOutput("reset_frame",  {28'd0, frame}, 0);
      checkOutput("reset_step",   {31'd0, step}, 0);
      checkOutput("reset_paused", {31'd0, paused}, 0);
      checkOutput("reset_dir",    {31'd0, dir}, 0);
      checkOutput("reset_speed",  {30'd0, speed}, 2);

      // Free-run forward at 250 cycles per frame, through the wrap 14 -> 0.
      waitUntil(3);
      reset = 1'b0;
      r0 = cyc;
      $display("[TB] free-run forward");
      for (int k = 1; k <= 16; k++) begin
         pushStep(r0 + 250 * k, k % NUM_FRAMES);
      end
      waitUntil(r0 + 4000);
      s = r0 + 4000;

      // Direction: toggles 4 cycles after the press, held key toggles once.
      $display("[TB] direction toggle");
      waitUntil(s + 10);
      applyStimulus(4'b0010, 1'b1);
      pushStep(s + 250, 0);
      pushStep(s + 500, 14);
      pushStep(s + 750, 13);
      waitUntil(s + 13);
      checkOutput("dir_before_event", {31'd0, dir}, 0);
      waitUntil(s + 14);
      checkOutput("dir_after_event", {31'd0, dir}, 1);
      waitUntil(s + 110);
      checkOutput("dir_held", {31'd0, dir}, 1);
      applyStimulus(4'b0010, 1'b0);
      waitUntil(s + 750);
      s = s + 750;

      // Pause with the prescaler at 100, then resume 149 cycles from a step.
      $display("[TB] pause and resume");
      waitUntil(s + 97);
      applyStimulus(4'b0001, 1'b1);
      waitUntil(s + 100);
      checkOutput("paused_before_event", {31'd0, paused}, 0);
      waitUntil(s + 101);
      checkOutput("paused_set", {31'd0, paused}, 1);
      waitUntil(s + 102);
      applyStimulus(4'b0001, 1'b0);
      waitUntil(s + 300);
      checkOutput("paused_frame_frozen", {28'd0, frame}, 13);
      checkOutput("paused_still", {31'd0, paused}, 1);
      waitUntil(s + 400);
      applyStimulus(4'b0001, 1'b1);
      pushStep(s + 553, 12);
      pushStep(s + 803, 11);
      waitUntil(s + 404);
      checkOutput("paused_resume", {31'd0, paused}, 0);
      waitUntil(s + 405);
      applyStimulus(4'b0001, 1'b0);
      waitUntil(s + 803);
      s = s + 803;

      // Faster: 2 -> 3 restarts the period at 125, a second press saturates.
      $display("[TB] faster");
      waitUntil(s + 6);
      applyStimulus(4'b0100, 1'b1);
      waitUntil(s + 9);
      checkOutput("speed_before_faster", {30'd0, speed}, 2);
      waitUntil(s + 10);
      checkOutput("speed_faster", {30'd0, speed}, 3);
      waitUntil(s + 11);
      applyStimulus(4'b0100, 1'b0);
      pushStep(s + 135, 10);
      pushStep(s + 260, 9);
      waitUntil(s + 30);
      applyStimulus(4'b0100, 1'b1);
      waitUntil(s + 34);
      checkOutput("speed_saturate_high", {30'd0, speed}, 3);
      waitUntil(s + 35);
      applyStimulus(4'b0100, 1'b0);
      waitUntil(s + 260);
      s = s + 260;

      // Slower four times: 3 -> 2 -> 1 -> 0 -> 0, then both keys together.
      $display("[TB] slower and simultaneous");
      for (int i = 0; i < 4; i++) begin
         t = s + 5 + 15 * i;
         waitUntil(t);
         applyStimulus(4'b1000, 1'b1);
         waitUntil(t + 4);
         checkOutput("speed_slower", {30'd0, speed}, slower_exp[i]);
         waitUntil(t + 5);
         applyStimulus(4'b1000, 1'b0);
      end
      pushStep(s + 1039, 8);
      waitUntil(s + 1100);
      applyStimulus(4'b1100, 1'b1);
      waitUntil(s + 1104);
      checkOutput("speed_both_keys", {30'd0, speed}, 0);
      waitUntil(s + 1105);
      applyStimulus(4'b1100, 1'b0);
      pushStep(s + 2039, 7);
      waitUntil(s + 2039);
      s = s + 2039;

      // Glitch and bounce are rejected, a 3-cycle stable low toggles once.
      $display("[TB] glitch and bounce");
      waitUntil(s + 10);
      applyStimulus(4'b0001, 1'b1);
      waitUntil(s + 11);
      applyStimulus(4'b0001, 1'b0);
      for (int i = 0; i < 10; i++) begin
         waitUntil(s + 20 + i);
         applyStimulus(4'b0001, (i % 2) == 0);
      end
      waitUntil(s + 30);
      applyStimulus(4'b0001, 1'b0);
      waitUntil(s + 40);
      checkOutput("paused_after_bounce", {31'd0, paused}, 0);
      applyStimulus(4'b0001, 1'b1);
      waitUntil(s + 43);
      checkOutput("paused_before_stable", {31'd0, paused}, 0);
      applyStimulus(4'b0001, 1'b0);
      waitUntil(s + 44);
      checkOutput("paused_stable_low", {31'd0, paused}, 1);
      waitUntil(s + 60);
      checkOutput("paused_single_toggle", {31'd0, paused}, 1);

      // Raise speed to 3 while paused, then reset asynchronously.
      for (int i = 0; i < 3; i++) begin
         t = s + 60 + 20 * i;
         waitUntil(t);
         applyStimulus(4'b0100, 1'b1);
         waitUntil(t + 4);
         checkOutput("speed_raise", {30'd0, speed}, i + 1);
         waitUntil(t + 5);
         applyStimulus(4'b0100, 1'b0);
      end
      waitUntil(s + 150);
      checkOutput("pre_reset_frame",  {28'd0, frame}, 7);
      checkOutput("pre_reset_dir",    {31'd0, dir}, 1);
      checkOutput("pre_reset_paused", {31'd0, paused}, 1);
      checkOutput("pre_reset_speed",  {30'd0, speed}, 3);

      $display("[TB] asynchronous reset");
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_frame",  {28'd0, frame}, 0);
      checkOutput("async_reset_step",   {31'd0, step}, 0);
      checkOutput("async_reset_paused", {31'd0, paused}, 0);
      checkOutput("async_reset_dir",    {31'd0, dir}, 0);
      checkOutput("async_reset_speed",  {30'd0, speed}, 2);
      waitUntil(s + 155);
      reset = 1'b0;
      r1 = cyc;
      pushStep(r1 + 250, 1);
      waitUntil(r1 + 249);
      checkOutput("frame_before_first_step", {28'd0, frame}, 0);
      waitUntil(r1 + 260);

      checkOutput("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
